// File: rtl/fpga_test_pkg.sv
// Shared types and widths for the FPGA test-program harness.
// Used by the out-channel checker and its FIFO.
package fpga_test_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} checker_state_t;

  localparam int ExpIdxW = 6;
  localparam int CntW    = 7;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Head word is valid on dout whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wp;
  logic [PW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);
  assign empty = (wp == rp);
  assign dout  = mem[rp[PW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) mem[wp[PW-1:0]] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/out_channel_checker.sv
// Compares the program's out-channel words, in order, against a
// preloaded expected table and drives the finished/success verdict.
module out_channel_checker
  import fpga_test_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int FifoDepth          = 4,
  parameter int NExpect            = 2,
  parameter int Timeout            = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          out_valid,
  output logic                          out_ready,
  input  logic [MemoryElementWidth-1:0] out_data,
  input  logic                          exp_we,
  input  logic [ExpIdxW-1:0]            exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  input  logic                          start,
  output logic                          finished,
  output logic                          success,
  output logic [ExpIdxW-1:0]            fail_index,
  output logic [CntW-1:0]               received_count
);

  localparam int MEW = MemoryElementWidth;
  localparam int AW  = (NExpect > 1) ? $clog2(NExpect) : 1;
  localparam int PW  = $clog2(FifoDepth);
  localparam int TW  = $clog2(Timeout + 1);

  localparam logic [CntW-1:0] NExp   = CntW'(NExpect);
  localparam logic [PW:0]     FullLv = (PW+1)'(FifoDepth);
  localparam logic [TW-1:0]   LastIdle = TW'(Timeout - 1);

  logic [MEW-1:0]  exp_tab [2**AW];
  checker_state_t  state;
  logic [CntW-1:0] cmp_idx;
  logic [TW-1:0]   idle_cnt;
  logic [PW:0]     level;
  logic [PW:0]     level_next;
  logic            fail_flag;

  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [MEW-1:0]  head;
  logic            at_end;
  logic            timeout_hit;
  logic            done_evt;
  logic            mismatch;

  assign push   = out_valid && out_ready;
  assign at_end = (cmp_idx == NExp);
  assign pop    = (state == RUN) && !empty && !at_end;

  assign mismatch    = head != exp_tab[cmp_idx[AW-1:0]];
  assign timeout_hit = (state == RUN) && !at_end && !pop &&
                       (idle_cnt == LastIdle);
  assign done_evt    = ((state == RUN) && at_end) || timeout_hit;

  // Occupancy lookahead lets out_ready be a flop without a bypass path.
  assign level_next = level + (PW+1)'(push) - (PW+1)'(pop);

  sync_fifo #(
    .WIDTH (MEW),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (out_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock) begin
    if (exp_we && state == IDLE)
      exp_tab[exp_addr[AW-1:0]] <= exp_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cmp_idx        <= '0;
      idle_cnt       <= '0;
      level          <= '0;
      fail_flag      <= 1'b0;
      finished       <= 1'b0;
      success        <= 1'b0;
      fail_index     <= ExpIdxW'(NExpect);
      received_count <= '0;
      out_ready      <= 1'b0;
    end else begin
      level     <= level_next;
      out_ready <= (level_next != FullLv) &&
                   !done_evt && (state != DONE);
      if (push && received_count != '1)
        received_count <= received_count + 1'b1;
      unique case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (pop) begin
            cmp_idx  <= cmp_idx + 1'b1;
            idle_cnt <= '0;
            if (mismatch) begin
              fail_flag <= 1'b1;
              if (!fail_flag)
                fail_index <= cmp_idx[ExpIdxW-1:0];
            end
          end else if (!at_end) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          // A word still queued or arriving at the end is an overflow.
          if (done_evt) begin
            state    <= DONE;
            finished <= 1'b1;
            success  <= at_end && !fail_flag && empty && !push;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed and randomized bench for out_channel_checker against a
// queue-based reference model of the out channel and verdict rules.
module tb_out_channel_checker;

  localparam int MEW = 12;
  localparam int FD  = 4;
  localparam int NE  = 2;
  localparam int TO  = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           out_valid = 1'b0;
  logic           out_ready;
  logic [MEW-1:0] out_data = '0;
  logic           exp_we = 1'b0;
  logic [5:0]     exp_addr = '0;
  logic [MEW-1:0] exp_data = '0;
  logic           start = 1'b0;
  logic           finished;
  logic           success;
  logic [5:0]     fail_index;
  logic [6:0]     received_count;

  always #5 clock = ~clock;

  out_channel_checker #(
    .MemoryElementWidth (MEW),
    .FifoDepth          (FD),
    .NExpect            (NE),
    .Timeout            (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .exp_we         (exp_we),
    .exp_addr       (exp_addr),
    .exp_data       (exp_data),
    .start          (start),
    .finished       (finished),
    .success        (success),
    .fail_index     (fail_index),
    .received_count (received_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: 0 = waiting for start, 1 = checking, 2 = verdict
  logic [MEW-1:0] q[$];
  logic [MEW-1:0] m_exp[NE];
  int             m_st;
  int             m_idx;
  int             m_idle;
  int             m_fidx;
  int             m_rcnt;
  bit             m_failed;
  bit             m_fin;
  bit             m_succ;
  bit             m_rdy;
  bit             m_acc;
  bit             m_live = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic model_step();
    logic [MEW-1:0] w;
    if (reset) begin
      q.delete();
      m_st = 0; m_idx = 0; m_idle = 0; m_fidx = NE; m_rcnt = 0;
      m_failed = 0; m_fin = 0; m_succ = 0; m_rdy = 0; m_acc = 0;
      m_live = 1;
      return;
    end
    m_acc = out_valid && m_rdy;
    case (m_st)
      0: begin
        if (exp_we) m_exp[exp_addr % NE] = exp_data;
        if (start) m_st = 1;
      end
      1: begin
        if (m_idx == NE) begin
          m_st = 2; m_fin = 1;
          m_succ = !m_failed && q.size() == 0 && !m_acc;
        end else if (q.size() > 0) begin
          w = q.pop_front();
          if (w != m_exp[m_idx] && !m_failed) begin
            m_failed = 1; m_fidx = m_idx;
          end
          m_idx++;
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_st = 2; m_fin = 1; m_succ = 0;
          end
        end
      end
      default: ;
    endcase
    if (m_acc) begin
      q.push_back(out_data);
      if (m_rcnt < 127) m_rcnt++;
    end
    m_rdy = q.size() < FD && m_st != 2;
  endtask

  task automatic cycle();
    @(negedge clock);
    if (m_live) begin
      chk("out_ready", out_ready, m_rdy);
      chk("finished", finished, m_fin);
      if (m_fin) chk("success", success, m_succ);
      chk("fail_index", fail_index, m_fidx);
      chk("received_count", received_count, m_rcnt);
    end
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; out_valid = 0; exp_we = 0; start = 0;
    cycle(); cycle();
    reset = 0;
    cycle();
  endtask

  task automatic load(input int a, input int v);
    exp_we = 1; exp_addr = 6'(a); exp_data = MEW'(v);
    cycle();
    exp_we = 0;
  endtask

  task automatic kick();
    start = 1; cycle(); start = 0;
  endtask

  task automatic send(input int v);
    out_valid = 1; out_data = MEW'(v);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_acc) begin
        out_valid = 0;
        return;
      end
    end
    out_valid = 0;
    bound_fail("send_bound");
  endtask

  task automatic wait_fin(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (finished === 1'b1) break;
      cycle();
    end
    chk("fin_bound", finished, 1);
  endtask

  initial begin
    int k;
    int st;
    int base;

    // fill FIFO before start, then overflow with a fifth word
    do_reset();
    load(0, 0); load(1, 1);
    out_valid = 1; k = 0; out_data = 0;
    for (int i = 0; i < 10 && k < 4; i++) begin
      cycle();
      if (m_acc) begin k++; out_data = MEW'(k); end
    end
    chk("fill_ready_low", out_ready, 0);
    chk("fill_count", received_count, 4);
    kick();
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_acc) begin out_valid = 0; break; end
    end
    out_valid = 0;
    wait_fin(20);
    chk("ovf_success", success, 0);
    chk("ovf_fail_index", fail_index, NE);
    chk("ovf_count", received_count, 5);

    // exact match
    do_reset();
    load(0, 1); load(1, 2);
    kick();
    send(1); send(2);
    cycle(); cycle();
    chk("match_fin", finished, 1);
    chk("match_success", success, 1);
    chk("match_fail_index", fail_index, 2);
    chk("match_count", received_count, 2);

    // mismatch on second word
    do_reset();
    kick();
    send(1); send(3);
    wait_fin(10);
    chk("mis_success", success, 0);
    chk("mis_fail_index", fail_index, 1);

    // timeout with no words
    do_reset();
    kick();
    for (int i = 0; i < TO; i++) cycle();
    chk("to_fin", finished, 1);
    chk("to_success", success, 0);
    chk("to_count", received_count, 0);

    // reset mid-run; table must survive
    do_reset();
    kick();
    send(1);
    do_reset();
    kick();
    send(1); send(2);
    wait_fin(10);
    chk("rst_success", success, 1);
    chk("rst_count", received_count, 2);

    // DONE absorbs further traffic
    out_valid = 1; out_data = 7;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("done_ready", out_ready, 0);
      chk("done_count", received_count, 2);
      chk("done_fin", finished, 1);
    end
    out_valid = 0;

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      do_reset();
      load(0, $urandom_range(0, 3));
      load(1, $urandom_range(0, 3));
      st = $urandom_range(0, 10);
      base = -1;
      for (int c = 0; c < 160; c++) begin
        start     = (c == st) || ($urandom_range(0, 15) == 0);
        out_valid = $urandom_range(0, 3) != 0;
        out_data  = MEW'($urandom_range(0, 3));
        exp_we    = $urandom_range(0, 7) == 0;
        exp_addr  = 6'($urandom_range(0, 63));
        exp_data  = MEW'($urandom_range(0, 3));
        cycle();
        if (m_fin && base < 0) base = c;
        if (base >= 0 && c > base + 4) break;
      end
      start = 0; out_valid = 0; exp_we = 0;
      chk("rand_fin", finished, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
